incr_pacer: RTL and testbench
=============================

# incr_pacer

Programmable strobe generator that drives the `incr_in` side of the counter datapath. It emits a burst of single-cycle increment pulses: count, spacing and abort are controlled by a start/stop handshake. It reports progress through an issued-pulse count and a one-cycle done strobe. Benches and top-level test harnesses use it so a counter's final value is known exactly from the burst configuration.

## Interface
Parameters:
- `CNT_W`, default 16: width of the burst length and the issued count. Matches the counter's internal width.
- `GAP_W`, default 8: width of the inter-pulse gap field.

Ports:
- `clk`  input  1  system clock. All logic updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start_in`  input  1  request to begin a burst. Sampled only in IDLE.
- `len_in`  input  CNT_W  number of pulses to issue. Latched with `start_in`.
- `gap_in`  input  GAP_W  low cycles between consecutive pulses. Latched with `start_in`.
- `stop_in`  input  1  abort the burst in progress.
- `incr_out`  output  1  increment strobe, one cycle per pulse. Connects to a counter's `incr_in`.
- `busy_out`  output  1  high whenever the state is not IDLE.
- `done_out`  output  1  one-cycle pulse when a burst finishes or is aborted.
- `issued_out`  output  CNT_W  number of pulses issued in the current or most recent burst.

## Operation
- FSM states: IDLE, PULSE, GAP, DONE. All outputs are decoded from registered state or counters; no output depends combinationally on inputs.
  - `incr_out` = (state == PULSE).
  - `busy_out` = (state != IDLE).
  - `done_out` = (state == DONE).
- IDLE transitions:
  - `start_in`=1, `stop_in`=0, `len_in`≠0: latch len and gap, clear `issued_out` to 0, go to PULSE.
  - `start_in`=1, `stop_in`=0, `len_in`=0: clear `issued_out`, go straight to DONE. No pulses are issued.
  - `start_in`=1 with `stop_in`=1: the start is ignored and the state stays IDLE.
- PULSE (exactly one cycle): `issued_out` increments by 1 at the closing edge. Next state, in priority order:
  - `stop_in`=1: DONE. The pulse already driven is counted.
  - issued+1 == len: DONE.
  - gap == 0: PULSE (back-to-back pulses).
  - otherwise: GAP, with the gap counter loaded to gap.
- GAP: the gap counter decrements each cycle.
  - `stop_in`=1: DONE.
  - Counter reaches 1: PULSE.
- DONE (one cycle): go to IDLE. `issued_out` holds its value until the next accepted start.
- `start_in` is ignored in every state except IDLE. `len_in` and `gap_in` changing mid-burst have no effect.
- `issued_out` never exceeds len, so it cannot wrap. len = 2^CNT_W−1 is legal.
- Reset: state=IDLE; `incr_out`, `busy_out`, `done_out` = 0; `issued_out` = 0; latched len and gap = 0. Reset mid-burst aborts with no `done_out` pulse.

## Timing
- Start sampled at edge t → first `incr_out` high in cycle t+1. `busy_out` rises in cycle t+1.
- Pulse period is gap+1 cycles. Pulse k (0-based) is high in cycle t+1+k·(gap+1).
- Last pulse in cycle t+1+(L−1)(gap+1). `done_out` is high the following cycle. `busy_out` falls one cycle after `done_out`.
- `issued_out` updates one cycle after each pulse. It equals L in the `done_out` cycle.
- `len_in`=0: `done_out` high in cycle t+1, `busy_out` high only in that cycle.
- Stop sampled at edge s while in PULSE or GAP → `done_out` in cycle s+1. No `incr_out` after edge s.
- Earliest restart: `start_in` sampled in the first IDLE cycle after DONE.

## Test plan
- Basic burst: `len_in`=5, `gap_in`=2, start at edge 0 → `incr_out` high in cycles 1, 4, 7, 10, 13; `done_out` in cycle 14; `issued_out`=5; a downstream counter reads 5.
- Back-to-back: `len_in`=4, `gap_in`=0 → `incr_out` high for cycles 1–4 continuously; `done_out` in cycle 5; `busy_out` high for cycles 1–5.
- Zero length: `len_in`=0 → no `incr_out`; `done_out` in cycle 1; `issued_out`=0.
- Abort: `len_in`=10, `gap_in`=3, `stop_in` pulsed at edge 6 (in GAP after the second pulse) → pulses in cycles 1 and 5 only; `done_out` in cycle 7; `issued_out`=2. Also check stop sampled in a PULSE cycle: that pulse is counted.
- Ignored inputs: `start_in` held high throughout a `len_in`=3, `gap_in`=1 burst, with `len_in` changed to 9 mid-burst → exactly 3 pulses. A new burst starts on the first IDLE cycle, first pulse 2 cycles after the old `done_out`. Separately, start with `stop_in`=1 in IDLE → nothing happens.
- Reset mid-burst: `rst` asserted at edge 4 of a `len_in`=8 burst → all outputs 0 from cycle 5; no `done_out`; the next start behaves as from power-up.

Source files
------------

// File: rtl/incr_pacer_if.sv
// incr_pacer_if: start/stop handshake plus progress outputs of the burst pacer.
//   master : drives start_in, len_in, gap_in, stop_in; observes incr/busy/done/issued.
//   slave  : the pacer itself.
interface incr_pacer_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned GAP_W = 8
);
  logic             start_in;
  logic [CNT_W-1:0] len_in;
  logic [GAP_W-1:0] gap_in;
  logic             stop_in;
  logic             incr_out;
  logic             busy_out;
  logic             done_out;
  logic [CNT_W-1:0] issued_out;

  modport master (
    output start_in, len_in, gap_in, stop_in,
    input  incr_out, busy_out, done_out, issued_out
  );

  modport slave (
    input  start_in, len_in, gap_in, stop_in,
    output incr_out, busy_out, done_out, issued_out
  );
endinterface

// File: rtl/incr_pacer.sv
// incr_pacer: emits a burst of len single-cycle increment strobes spaced by gap
// idle cycles, abortable with stop_in, reporting the issued count and a done strobe.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : incr_pacer_if.slave (start/len/gap/stop in; incr/busy/done/issued out)
module incr_pacer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned GAP_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  incr_pacer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_len;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] w_issued_inc;

  // issued never exceeds len, so this increment cannot wrap
  assign w_issued_inc = r_issued + CNT_W'(1);

  // Burst sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_issued  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // a simultaneous stop vetoes the start
          if (bus.start_in && !bus.stop_in) begin
            r_len    <= bus.len_in;
            r_gap    <= bus.gap_in;
            r_issued <= '0;
            r_state  <= (bus.len_in == '0) ? DONE : PULSE;
          end
        end
        PULSE: begin
          // the pulse driven this cycle is always counted, even on abort
          r_issued <= w_issued_inc;
          if (bus.stop_in || (w_issued_inc == r_len)) begin
            r_state <= DONE;
          end else if (r_gap == '0) begin
            r_state <= PULSE;
          end else begin
            r_gap_cnt <= r_gap;
            r_state   <= GAP;
          end
        end
        GAP: begin
          // gap counter is loaded with gap, so gap cycles elapse before the next pulse
          if (bus.stop_in) begin
            r_state <= DONE;
          end else if (r_gap_cnt == GAP_W'(1)) begin
            r_state <= PULSE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only
  assign bus.incr_out   = (r_state == PULSE);
  assign bus.busy_out   = (r_state != IDLE);
  assign bus.done_out   = (r_state == DONE);
  assign bus.issued_out = r_issued;

endmodule

// File: tb/tb_incr_pacer.sv
// tb_incr_pacer: table-driven directed checks of incr_pacer. Vector j holds the
// inputs sampled at edge j and the outputs expected in the cycle after that edge.
module tb_incr_pacer;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned GAP_W = 8;

  logic clk;
  logic rst;

  incr_pacer_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  incr_pacer #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] len;
    logic [GAP_W-1:0] gap;
    logic             e_incr;
    logic             e_busy;
    logic             e_done;
    logic [CNT_W-1:0] e_iss;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  int   ds_cnt = 0;   // downstream counter fed by incr_out
  int   done_cnt = 0; // total done strobes observed

  always @(posedge clk) begin
    if (rst) ds_cnt <= 0;
    else if (bus.incr_out === 1'b1) ds_cnt <= ds_cnt + 1;
    if (bus.done_out === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void v(input logic r, input logic s, input logic p,
                            input logic [CNT_W-1:0] l, input logic [GAP_W-1:0] g,
                            input logic ei, input logic eb, input logic ed,
                            input logic [CNT_W-1:0] es);
    vq.push_back(vec_t'{r, s, p, l, g, ei, eb, ed, es});
  endfunction

  task automatic drive(input logic r, input logic s, input logic p,
                       input logic [CNT_W-1:0] l, input logic [GAP_W-1:0] g);
    rst          = r;
    bus.start_in = s;
    bus.stop_in  = p;
    bus.len_in   = l;
    bus.gap_in   = g;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].start, vq[i].stop, vq[i].len, vq[i].gap);
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].incr", tag, i), 32'(bus.incr_out), 32'(vq[i].e_incr));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(bus.busy_out), 32'(vq[i].e_busy));
      chk($sformatf("%s[%0d].done", tag, i), 32'(bus.done_out), 32'(vq[i].e_done));
      chk($sformatf("%s[%0d].issued", tag, i), 32'(bus.issued_out), 32'(vq[i].e_iss));
    end
    vq.delete();
  endtask

  int done_snap;

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset state, then basic burst len=5 gap=2
    v(1,0,0,0,0, 0,0,0,0);
    v(1,0,0,0,0, 0,0,0,0);
    v(0,1,0,5,2, 1,1,0,0);   // c1 pulse
    v(0,0,0,0,0, 0,1,0,1);   // c2
    v(0,0,0,0,0, 0,1,0,1);   // c3
    v(0,0,0,0,0, 1,1,0,1);   // c4 pulse
    v(0,0,0,0,0, 0,1,0,2);
    v(0,0,0,0,0, 0,1,0,2);
    v(0,0,0,0,0, 1,1,0,2);   // c7 pulse
    v(0,0,0,0,0, 0,1,0,3);
    v(0,0,0,0,0, 0,1,0,3);
    v(0,0,0,0,0, 1,1,0,3);   // c10 pulse
    v(0,0,0,0,0, 0,1,0,4);
    v(0,0,0,0,0, 0,1,0,4);
    v(0,0,0,0,0, 1,1,0,4);   // c13 pulse
    v(0,0,0,0,0, 0,1,1,5);   // c14 done
    v(0,0,0,0,0, 0,0,0,5);   // c15 idle, issued holds
    run_table("basic");
    chk("basic.downstream_count", 32'(ds_cnt), 32'd5);

    // Back-to-back len=4 gap=0
    v(0,1,0,4,0, 1,1,0,0);
    v(0,0,0,0,0, 1,1,0,1);
    v(0,0,0,0,0, 1,1,0,2);
    v(0,0,0,0,0, 1,1,0,3);
    v(0,0,0,0,0, 0,1,1,4);
    v(0,0,0,0,0, 0,0,0,4);
    // Zero length
    v(0,1,0,0,5, 0,1,1,0);
    v(0,0,0,0,0, 0,0,0,0);
    // Abort during GAP: len=10 gap=3, stop at edge 6
    v(0,1,0,10,3, 1,1,0,0);
    v(0,0,0,0,0, 0,1,0,1);
    v(0,0,0,0,0, 0,1,0,1);
    v(0,0,0,0,0, 0,1,0,1);
    v(0,0,0,0,0, 1,1,0,1);
    v(0,0,0,0,0, 0,1,0,2);
    v(0,0,1,0,0, 0,1,1,2);
    v(0,0,0,0,0, 0,0,0,2);
    // start held high, len changed mid-burst, restart on first IDLE cycle
    v(0,1,0,3,1, 1,1,0,0);
    v(0,1,0,9,1, 0,1,0,1);
    v(0,1,0,9,1, 1,1,0,1);
    v(0,1,0,9,1, 0,1,0,2);
    v(0,1,0,9,1, 1,1,0,2);
    v(0,1,0,9,1, 0,1,1,3);
    v(0,1,0,9,1, 0,0,0,3);   // start ignored in DONE
    v(0,1,0,9,1, 1,1,0,0);   // restart accepted in IDLE
    v(0,0,1,9,1, 0,1,1,1);   // stop in PULSE: that pulse counted
    v(0,0,0,0,0, 0,0,0,1);
    // start with stop in IDLE is ignored
    v(0,1,1,5,0, 0,0,0,1);
    v(0,0,0,0,0, 0,0,0,1);
    run_table("mix");
    chk("mix.downstream_count", 32'(ds_cnt), 32'd15);

    // Reset mid-burst: len=8 gap=0, rst sampled at edge 4
    done_snap = done_cnt;
    drive(1'b0, 1'b1, 1'b0, 16'd8, 8'd0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      chk($sformatf("rstmid.c%0d.incr", c), 32'(bus.incr_out), 32'd1);
      chk($sformatf("rstmid.c%0d.issued", c), 32'(bus.issued_out), 32'(c - 1));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid.incr", 32'(bus.incr_out), 32'd0);
    chk("rstmid.busy", 32'(bus.busy_out), 32'd0);
    chk("rstmid.done", 32'(bus.done_out), 32'd0);
    chk("rstmid.issued", 32'(bus.issued_out), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rstmid.idle%0d.busy", c), 32'(bus.busy_out), 32'd0);
    end
    chk("rstmid.no_done", 32'(done_cnt), 32'(done_snap));

    // Fresh burst after reset: len=2 gap=3
    v(0,1,0,2,3, 1,1,0,0);
    v(0,0,0,0,0, 0,1,0,1);
    v(0,0,0,0,0, 0,1,0,1);
    v(0,0,0,0,0, 0,1,0,1);
    v(0,0,0,0,0, 1,1,0,1);
    v(0,0,0,0,0, 0,1,1,2);
    v(0,0,0,0,0, 0,0,0,2);
    run_table("post_rst");
    chk("post_rst.downstream_count", 32'(ds_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
